// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the future receiver:
// sequencer states, parity encodings and the parameter legality check.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic bit uart_params_legal(input int data_bits,
                                             input int parity,
                                             input int stop_bits);
        return (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: takes one word per valid/ready handshake and
// shifts it out as start, data (LSB first), optional parity and stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (!uart_params_legal(DATA_BITS, PARITY, STOP_BITS)) begin : g_illegal_params
        $error("uart_tx_ctrl: illegal DATA_BITS/PARITY/STOP_BITS combination");
    end

    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != PAR_NONE);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 ready_q;
    logic                 busy_q;
    logic                 data_parity;

    assign data_parity = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        serial_d   = serial_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d  = tx_data;
                    parity_d = data_parity;
                    state_d  = ST_SYNC;
                end
            end
            // Waiting for a fresh tick guarantees a full-length start bit.
            ST_SYNC: begin
                if (baud_tick) begin
                    serial_d = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    serial_d  = shift_q[0];
                    bit_cnt_d = 4'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (HAS_PARITY) begin
                            serial_d = parity_q;
                            state_d  = ST_PARITY;
                        end else begin
                            serial_d   = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    serial_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                serial_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Handshake flags follow the next state so they are registered yet
    // already reflect an accept or a frame end in the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            serial_q   <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            serial_q   <= serial_d;
            done_q     <= done_d;
            ready_q    <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign tx_ready  = ready_q;
    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: four parameterisations driven with
// directed and random words, compared against a frame-level bit-list model.
module tb_uart_tx_ctrl;

    localparam int N = 4;
    localparam int DB [N] = '{8, 8, 8, 7};
    localparam int PB [N] = '{0, 1, 2, 0};
    localparam int SB [N] = '{1, 1, 1, 2};

    typedef logic bitq_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    int         tick_cnt = 0;
    logic [8:0] tx_data  [N];
    logic       tx_valid [N];
    logic       tx_ready [N];
    logic       tx_serial[N];
    logic       tx_busy  [N];
    logic       tx_done  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Free-running baud generator: one-cycle pulse every 4 clocks.
    always @(posedge clk) begin
        tick_cnt  <= (tick_cnt == 3) ? 0 : tick_cnt + 1;
        baud_tick <= (tick_cnt == 2);
    end

    uart_tx_ctrl u_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_serial(tx_serial[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
    );

    uart_tx_ctrl #(.PARITY(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_serial(tx_serial[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
    );

    uart_tx_ctrl #(.PARITY(2)) u_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_serial(tx_serial[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
    );

    uart_tx_ctrl #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
        .tx_serial(tx_serial[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: line level for each bit period, start to last stop.
    function automatic bitq_t frame_bits(input int id, input logic [8:0] w);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < DB[id]; i++) begin
            q.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (PB[id] == 1) q.push_back(logic'(ones % 2));
        if (PB[id] == 2) q.push_back(logic'(1 - ones % 2));
        for (int i = 0; i < SB[id]; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after the accept edge; returns in the tx_done cycle.
    task automatic check_frame(input int id, input logic [8:0] w, input bit noise, output int lat);
        bitq_t exp;
        int    n;
        bit    got_start;
        logic  t;
        exp = frame_bits(id, w);
        n = exp.size();
        got_start = 0;
        lat = 0;
        check_eq("accept_ready", tx_ready[id], 1'b0);
        check_eq("accept_busy", tx_busy[id], 1'b1);
        for (int k = 0; k < 8 && !got_start; k++) begin
            t = baud_tick;
            step();
            lat++;
            check_eq("sync_line", tx_serial[id], t ? 1'b0 : 1'b1);
            if (t) got_start = 1;
        end
        check_eq("start_seen", got_start, 1'b1);
        for (int c = 0; c < n * 4; c++) begin
            if (noise) begin
                if (c < n * 4 - 2) begin
                    tx_valid[id] = 1'($urandom);
                    tx_data[id]  = 9'($urandom);
                end else begin
                    tx_valid[id] = 1'b0;
                end
            end
            check_eq($sformatf("dut%0d_bit%0d", id, c / 4), tx_serial[id], exp[c / 4]);
            check_eq("frame_ready", tx_ready[id], 1'b0);
            check_eq("frame_busy", tx_busy[id], 1'b1);
            check_eq("frame_done", tx_done[id], 1'b0);
            step();
        end
        check_eq("end_done", tx_done[id], 1'b1);
        check_eq("end_ready", tx_ready[id], 1'b1);
        check_eq("end_busy", tx_busy[id], 1'b0);
        check_eq("end_line", tx_serial[id], 1'b1);
        $display("frame dut%0d data %0h bits %0d latency %0d", id, w, n, lat);
    endtask

    task automatic wait_ready(input int id);
        for (int k = 0; k < 100 && !tx_ready[id]; k++) step();
        check_eq("ready_wait", tx_ready[id], 1'b1);
    endtask

    task automatic send(input int id, input logic [8:0] w, input bit noise, output int lat);
        wait_ready(id);
        tx_data[id]  = w;
        tx_valid[id] = 1'b1;
        step();
        tx_valid[id] = 1'b0;
        tx_data[id]  = ~w;
        check_frame(id, w, noise, lat);
        step();
        check_eq("done_single", tx_done[id], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   id;
        logic t;
        bit   got_start;
        for (int i = 0; i < N; i++) begin
            tx_data[i]  = '0;
            tx_valid[i] = 1'b0;
        end

        repeat (3) step();
        for (int i = 0; i < N; i++) begin
            check_eq("rst_line", tx_serial[i], 1'b1);
            check_eq("rst_ready", tx_ready[i], 1'b1);
            check_eq("rst_busy", tx_busy[i], 1'b0);
            check_eq("rst_done", tx_done[i], 1'b0);
        end
        rst = 1'b1;
        repeat (2) step();

        send(0, 9'h0A5, 1'b0, lat);
        send(1, 9'h0A5, 1'b0, lat);
        send(2, 9'h0A5, 1'b0, lat);
        send(2, 9'h001, 1'b0, lat);
        send(3, 9'h07F, 1'b0, lat);

        // Back-to-back with tx_valid held high across the tx_done cycle.
        wait_ready(0);
        tx_data[0]  = 9'h000;
        tx_valid[0] = 1'b1;
        step();
        tx_data[0] = 9'h0FF;
        check_frame(0, 9'h000, 1'b0, lat);
        step();
        tx_valid[0] = 1'b0;
        check_frame(0, 9'h0FF, 1'b0, lat);
        check_eq("b2b_gap_cycles", lat + 1, 4);
        step();

        // Word accepted in the same cycle as a tick.
        wait_ready(0);
        for (int k = 0; k < 8 && !baud_tick; k++) step();
        tx_data[0]  = 9'h05A;
        tx_valid[0] = 1'b1;
        step();
        tx_valid[0] = 1'b0;
        check_frame(0, 9'h05A, 1'b0, lat);
        check_eq("tick_phase_lat", lat, 4);
        step();

        // Reset during data bit 3 abandons the frame with no tx_done.
        wait_ready(0);
        tx_data[0]  = 9'h000;
        tx_valid[0] = 1'b1;
        step();
        tx_valid[0] = 1'b0;
        got_start = 0;
        for (int k = 0; k < 8 && !got_start; k++) begin
            t = baud_tick;
            step();
            if (t) got_start = 1;
        end
        check_eq("rst_mid_start", got_start, 1'b1);
        repeat (18) step();
        check_eq("rst_mid_pre", tx_serial[0], 1'b0);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_line", tx_serial[0], 1'b1);
        check_eq("rst_mid_busy", tx_busy[0], 1'b0);
        check_eq("rst_mid_ready", tx_ready[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("rst_mid_done", tx_done[0], 1'b0);
        end
        rst = 1'b1;
        step();
        check_eq("rst_rel_done", tx_done[0], 1'b0);
        send(0, 9'h03C, 1'b0, lat);

        for (int it = 0; it < 12; it++) begin
            id = int'($urandom_range(0, N - 1));
            repeat ($urandom_range(0, 5)) step();
            send(id, 9'($urandom), (it % 3) == 0, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
